// File: rtl/sw_pkg.sv
// Shared constants, symbol type and scheduler state encoding for the SW read scheduler.
package sw_pkg;

  localparam int DATA_WIDTH  = 4;
  localparam int IN_SIZE     = 252;
  localparam int SYM_CNT     = IN_SIZE / DATA_WIDTH;
  localparam int SCORE_WIDTH = 10;
  localparam int PTR_WIDTH   = $clog2(SYM_CNT);

  typedef logic [DATA_WIDTH-1:0] sym_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READ,
    STREAM,
    WAIT_SCORE,
    REPORT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sw_sym_serializer.sv
// First-word-fall-through serializer: emits a packed sequence one symbol per consume, MSB-first.
module sw_sym_serializer
  import sw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [IN_SIZE-1:0] data,
  input  logic               rd_en,
  output logic               empty,
  output sym_t               sym_out,
  output logic               last
);

  logic [IN_SIZE-1:0]   shift_reg;
  logic [PTR_WIDTH-1:0] ptr_reg;
  logic                 empty_reg;
  logic                 consume;

  assign consume = rd_en && !empty_reg;
  assign last    = !empty_reg && (ptr_reg == PTR_WIDTH'(SYM_CNT - 1));
  assign empty   = empty_reg;
  assign sym_out = shift_reg[IN_SIZE-1 -: DATA_WIDTH];

  // The head symbol always sits in the MSBs; consuming shifts the next one up.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      shift_reg <= '0;
      ptr_reg   <= '0;
      empty_reg <= 1'b1;
    end else if (load) begin
      shift_reg <= data;
      ptr_reg   <= '0;
      empty_reg <= 1'b0;
    end else if (consume) begin
      shift_reg <= shift_reg << DATA_WIDTH;
      if (last) begin
        empty_reg <= 1'b1;
      end else begin
        ptr_reg <= ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_read_scheduler.sv
// Feeds reference/read symbol streams to the SW core, reports per-read scores and the batch best.
// Optional watchdog on STREAM/WAIT_SCORE enabled by defining SW_TIMEOUT_EN.
module sw_read_scheduler
  import sw_pkg::*;
#(
  parameter int NUM_READS = 100,
  parameter int IDX_WIDTH = 7
`ifdef SW_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ref_valid,
  input  logic [IN_SIZE-1:0]     ref_data,
  output logic                   ref_ready,
  input  logic                   read_valid,
  input  logic [IN_SIZE-1:0]     read_data,
  output logic                   read_ready,
  output logic                   buf1_empty,
  output logic [DATA_WIDTH-1:0]  buf1_out,
  input  logic                   rd1_en,
  output logic                   buf2_empty,
  output logic [DATA_WIDTH-1:0]  buf2_out,
  input  logic                   rd2_en,
  input  logic                   sw_done,
  input  logic [SCORE_WIDTH-1:0] score,
  output logic                   res_valid,
  output logic [IDX_WIDTH-1:0]   res_idx,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic [IDX_WIDTH-1:0]   best_idx,
  output logic                   batch_done,
  output logic                   proto_err
);

  sched_state_t           state_reg, state_next;
  logic [IN_SIZE-1:0]     ref_reg;
  logic [IDX_WIDTH-1:0]   idx_reg;
  logic [SCORE_WIDTH-1:0] score_reg;
  logic [SCORE_WIDTH-1:0] best_score_reg;
  logic [IDX_WIDTH-1:0]   best_idx_reg;
  logic                   proto_err_reg;

  logic ref_fire, read_fire, score_fire, stream_fin, last_read;
  logic timeout_fire, timeout_hit;

  logic [IN_SIZE-1:0] ser_data  [2];
  logic               ser_rd_en [2];
  logic               ser_empty [2];
  logic               ser_last  [2];
  sym_t               ser_sym   [2];

  assign ref_fire   = ref_valid && ref_ready;
  assign read_fire  = read_valid && read_ready;
  assign score_fire = sw_done && (state_reg == WAIT_SCORE);
  assign last_read  = (idx_reg == IDX_WIDTH'(NUM_READS - 1));
  // A stream is finished once each buffer is empty or is handing over its final symbol now.
  assign stream_fin = (ser_empty[0] || (ser_last[0] && ser_rd_en[0])) &&
                      (ser_empty[1] || (ser_last[1] && ser_rd_en[1]));

`ifdef SW_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYC);
  logic [WD_WIDTH-1:0] wd_reg;

  assign timeout_fire = ((state_reg == STREAM) || (state_reg == WAIT_SCORE)) &&
                        (wd_reg == WD_WIDTH'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst || read_fire) begin
      wd_reg <= '0;
    end else if ((state_reg == STREAM) || (state_reg == WAIT_SCORE)) begin
      wd_reg <= wd_reg + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // A genuine score arriving in the same cycle as the watchdog wins.
  assign timeout_hit = timeout_fire && !score_fire;

  assign ser_data[0]  = ref_reg;
  assign ser_data[1]  = read_data;
  assign ser_rd_en[0] = rd1_en;
  assign ser_rd_en[1] = rd2_en;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ser
    sw_sym_serializer u_ser (
      .clk     (clk),
      .rst     (rst),
      .load    (read_fire),
      .flush   (timeout_hit),
      .data    (ser_data[gi]),
      .rd_en   (ser_rd_en[gi]),
      .empty   (ser_empty[gi]),
      .sym_out (ser_sym[gi]),
      .last    (ser_last[gi])
    );
  end

  assign buf1_empty = ser_empty[0];
  assign buf2_empty = ser_empty[1];
  assign buf1_out   = ser_sym[0];
  assign buf2_out   = ser_sym[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ref_ready  = 1'b0;
    read_ready = 1'b0;
    res_valid  = 1'b0;
    batch_done = 1'b0;
    case (state_reg)
      IDLE: begin
        ref_ready = 1'b1;
        if (ref_valid) state_next = WAIT_READ;
      end
      WAIT_READ: begin
        read_ready = 1'b1;
        if (read_valid) state_next = STREAM;
      end
      STREAM: begin
        if (timeout_fire)    state_next = REPORT;
        else if (stream_fin) state_next = WAIT_SCORE;
      end
      WAIT_SCORE: begin
        if (sw_done || timeout_fire) state_next = REPORT;
      end
      REPORT: begin
        res_valid  = 1'b1;
        state_next = last_read ? DONE : WAIT_READ;
      end
      DONE: begin
        ref_ready  = 1'b1;
        batch_done = 1'b1;
        if (ref_valid) state_next = WAIT_READ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Best tracking updates on the score edge so it is already current while res_valid is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_reg        <= '0;
      idx_reg        <= '0;
      score_reg      <= '0;
      best_score_reg <= '0;
      best_idx_reg   <= '0;
      proto_err_reg  <= 1'b0;
    end else begin
      if (ref_fire) begin
        ref_reg <= ref_data;
        if (state_reg == DONE) begin
          idx_reg        <= '0;
          best_score_reg <= '0;
          best_idx_reg   <= '0;
        end
      end
      if (score_fire) begin
        score_reg <= score;
        if (score > best_score_reg) begin
          best_score_reg <= score;
          best_idx_reg   <= idx_reg;
        end
      end else if (timeout_hit) begin
        score_reg <= '0;
      end
      if ((state_reg == REPORT) && !last_read) begin
        idx_reg <= idx_reg + 1'b1;
      end
      if ((sw_done && (state_reg != WAIT_SCORE)) || timeout_hit) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign res_idx    = idx_reg;
  assign res_score  = score_reg;
  assign best_score = best_score_reg;
  assign best_idx   = best_idx_reg;
  assign proto_err  = proto_err_reg;

endmodule
